// File: rtl/i2s_pkg.sv
// Shared I2S types and defaults for the codec boundary blocks.
// Channel and receiver state encodings.
package i2s_pkg;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_ch_e;

  typedef enum logic [1:0] {
    ALIGN,
    SHIFT,
    DONE
  } i2s_rx_state_e;

  localparam int I2S_DEFAULT_DATA_WIDTH = 24;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: data, valid/ready, last.
// Master drives payload, slave drives ready.
interface axis_if #(
  parameter int DATA_WIDTH = 24
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/i2s_sync.sv
// Multi-flop synchronizer with a registered rising-edge pulse.
// The pulse lags the synced level by one clk.
module i2s_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
    end
  end

  assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversampled codec pins to AXI-Stream beats.
// Left beat first; tlast marks the right channel.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = I2S_DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic   clk,
  input  logic   rst,
  axis_if.master axis_rx,
  input  logic   lrck,
  input  logic   sclk,
  input  logic   sdi,
  output logic   overflow,
  output logic   frame_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic bit_en;
  logic sclk_s;
  logic lrck_s;
  logic sdi_s;
  logic lrck_rise_unused;
  logic sdi_rise_unused;

  i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk (clk),
    .rst (rst),
    .din (sclk),
    .dout(sclk_s),
    .rise(bit_en)
  );

  i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrck (
    .clk (clk),
    .rst (rst),
    .din (lrck),
    .dout(lrck_s),
    .rise(lrck_rise_unused)
  );

  i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sdi (
    .clk (clk),
    .rst (rst),
    .din (sdi),
    .dout(sdi_s),
    .rise(sdi_rise_unused)
  );

  i2s_rx_state_e         state;
  i2s_ch_e               ch;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  lrck_q;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;

  logic                  slot_start;
  logic [DATA_WIDTH-1:0] sh_next;
  logic                  can_load;

  assign slot_start = lrck_s != lrck_q;
  assign sh_next    = {shreg[DATA_WIDTH-2:0], sdi_s};
  assign can_load   = !tvalid || axis_rx.tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ALIGN;
      ch        <= CH_LEFT;
      bit_cnt   <= '0;
      shreg     <= '0;
      lrck_q    <= 1'b0;
      tdata     <= '0;
      tvalid    <= 1'b0;
      tlast     <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (tvalid && axis_rx.tready) tvalid <= 1'b0;
      if (bit_en) begin
        lrck_q <= lrck_s;
        unique case (state)
          ALIGN: begin
            if (slot_start && !lrck_s) begin
              state   <= SHIFT;
              ch      <= CH_LEFT;
              bit_cnt <= '0;
            end
          end
          SHIFT: begin
            if (slot_start) begin
              frame_err <= 1'b1;
              bit_cnt   <= '0;
              ch        <= CH_LEFT;
              state     <= lrck_s ? ALIGN : SHIFT;
            end else begin
              shreg   <= sh_next;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                if (can_load) begin
                  tdata  <= sh_next;
                  tlast  <= (ch == CH_RIGHT);
                  tvalid <= 1'b1;
                  state  <= DONE;
                end else begin
                  overflow <= 1'b1;
                  state    <= ALIGN;
                end
              end
            end
          end
          DONE: begin
            if (slot_start) begin
              state   <= SHIFT;
              ch      <= i2s_ch_e'(lrck_s);
              bit_cnt <= '0;
            end
          end
          default: state <= ALIGN;
        endcase
      end
    end
  end

  assign axis_rx.tdata  = tdata;
  assign axis_rx.tvalid = tvalid;
  assign axis_rx.tlast  = tlast;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S frames, checks beats against a queue model.
// clk = 8x sclk, 32 sclk per slot.
module tb_i2s_rx;

  localparam int DW = 24;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lrck = 1'b1;
  logic sclk = 1'b0;
  logic sdi = 1'b0;
  logic overflow;
  logic frame_err;
  logic tready = 1'b1;
  int   rdy_mode = 0;

  int n_vec = 0;
  int n_err = 0;

  beat_t exp_q[$];

  axis_if #(.DATA_WIDTH(DW)) axis ();

  assign axis.tready = tready;

  i2s_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .axis_rx  (axis.master),
    .lrck     (lrck),
    .sclk     (sclk),
    .sdi      (sdi),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // tready moves just after posedge so negedge samples see the next edge's value
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: tready = 1'b1;
      1: tready = 1'b0;
      default: tready = ~tready;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  logic          pv_valid = 1'b0;
  logic          pv_ready = 1'b0;
  logic [DW-1:0] pv_data  = '0;
  logic          pv_last  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      pv_valid <= 1'b0;
    end else begin
      if (pv_valid && !pv_ready) begin
        check("stall_valid", 32'(axis.tvalid), 32'd1);
        check("stall_data", 32'(axis.tdata), 32'(pv_data));
        check("stall_last", 32'(axis.tlast), 32'(pv_last));
      end
      if (axis.tvalid && tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(axis.tdata), 32'hFFFF_FFFF);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_data", 32'(axis.tdata), 32'(b.data));
          check("beat_last", 32'(axis.tlast), 32'(b.last));
        end
      end
      pv_valid <= axis.tvalid;
      pv_ready <= tready;
      pv_data  <= axis.tdata;
      pv_last  <= axis.tlast;
    end
  end

  // One slot: bit 0 is the I2S delay bit, bits 1..DW carry MSB..LSB.
  task automatic send_slot(input logic lr, input logic [DW-1:0] d,
                           input int nbits, input bit chk);
    for (int i = 0; i < nbits; i++) begin
      lrck = lr;
      if (i >= 1 && i <= DW) sdi = d[DW-i];
      else sdi = 1'($urandom);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (chk && i == DW && k == 3) check("lat_early", 32'(axis.tvalid), 32'd0);
        if (chk && i == DW && k == 4) check("lat_rise", 32'(axis.tvalid), 32'd1);
      end
    end
    sclk = 1'b0;
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input logic last);
    beat_t b;
    b.data = d;
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] l;
    logic [DW-1:0] r;

    // reset state
    rdy_mode = 0;
    repeat (5) @(negedge clk);
    check("rst_tvalid", 32'(axis.tvalid), 32'd0);
    check("rst_tdata", 32'(axis.tdata), 32'd0);
    check("rst_tlast", 32'(axis.tlast), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);

    // release reset mid right slot: nothing until the next left slot
    rst = 1'b0;
    send_slot(1'b1, 24'h123456, 20, 1'b0);

    // directed frame then random frames, ready held high
    expect_beat(24'hA5A5A5, 1'b0);
    send_slot(1'b0, 24'hA5A5A5, 32, 1'b1);
    expect_beat(24'h5A5A5A, 1'b1);
    send_slot(1'b1, 24'h5A5A5A, 32, 1'b1);
    for (int f = 0; f < 4; f++) begin
      l = DW'($urandom);
      r = DW'($urandom);
      expect_beat(l, 1'b0);
      send_slot(1'b0, l, 32, 1'b1);
      expect_beat(r, 1'b1);
      send_slot(1'b1, r, 32, 1'b1);
    end
    drain("drain_random");
    check("ovf_clean", 32'(overflow), 32'd0);
    check("ferr_clean", 32'(frame_err), 32'd0);

    // stall a full frame: left held, right dropped
    rdy_mode = 1;
    expect_beat(24'h000001, 1'b0);
    send_slot(1'b0, 24'h000001, 32, 1'b0);
    send_slot(1'b1, 24'h000002, 32, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("held_data", 32'(axis.tdata), 32'h000001);
    rdy_mode = 0;
    l = DW'($urandom);
    r = DW'($urandom);
    expect_beat(l, 1'b0);
    send_slot(1'b0, l, 32, 1'b0);
    expect_beat(r, 1'b1);
    send_slot(1'b1, r, 32, 1'b1);
    drain("drain_ovf");

    // short left slot: frame error, that frame yields nothing
    send_slot(1'b0, 24'hFFFF00, 17, 1'b0);
    send_slot(1'b1, 24'h0F0F0F, 32, 1'b0);
    check("ferr_set", 32'(frame_err), 32'd1);
    l = DW'($urandom);
    r = DW'($urandom);
    expect_beat(l, 1'b0);
    send_slot(1'b0, l, 32, 1'b1);
    expect_beat(r, 1'b1);
    send_slot(1'b1, r, 32, 1'b1);
    drain("drain_ferr");

    // extreme values with ready toggling every cycle
    rdy_mode = 2;
    for (int f = 0; f < 2; f++) begin
      expect_beat(24'h800000, 1'b0);
      send_slot(1'b0, 24'h800000, 32, 1'b0);
      expect_beat(24'h7FFFFF, 1'b1);
      send_slot(1'b1, 24'h7FFFFF, 32, 1'b0);
    end
    drain("drain_toggle");

    // reset while a beat is presented and stalled
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    send_slot(1'b0, 24'h3C3C3C, 26, 1'b0);
    check("pre_rst_valid", 32'(axis.tvalid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_tvalid", 32'(axis.tvalid), 32'd0);
    check("rst2_ovf", 32'(overflow), 32'd0);
    check("rst2_ferr", 32'(frame_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

Receives serial audio from an external I2S ADC and presents each channel sample as a beat on an AXI-Stream master, left then right. Sits opposite `i2s_tx` at the codec boundary, feeding the effects pipeline. `sclk`, `lrck` and `sdi` come from the codec and are oversampled in the `clk` domain; the block drives no codec clocks.

## Interface
- `DATA_WIDTH`, default 24: sample bits captured per channel, MSB first.
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk`, `lrck` and `sdi`, minimum 2.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `axis_rx`  `axis_if.master`  DATA_WIDTH  output samples. Uses `tdata`, `tvalid`, `tready` and `tlast`; `tlast`=1 marks the right channel.
- `lrck`  in  1  word select from the codec: 0 = left, 1 = right.
- `sclk`  in  1  serial bit clock from the codec.
- `sdi`  in  1  serial data from the codec.
- `overflow`  out  1  sticky; a completed sample was dropped because of backpressure.
- `frame_err`  out  1  sticky; `lrck` toggled before DATA_WIDTH bits were captured.

## Operation
- Synchronization:
  - `sclk`, `lrck` and `sdi` each pass through SYNC_STAGES flops of equal depth.
  - A one-cycle `bit_en` pulse fires when synced `sclk` goes 0→1.
  - All protocol logic advances only on `bit_en`.
- Slot start:
  - On each `bit_en`, compare synced `lrck` with `lrck_q`, the value latched at the previous `bit_en`. A difference is a slot start.
  - The I2S one-bit delay applies: the bit sampled on the slot-start edge is ignored, and the MSB is sampled on the next `bit_en`.
- State machine (package enum):
  - ALIGN (reset state): waits for a slot start with new `lrck`=0, the start of a left slot. Then → SHIFT with channel=left and `bit_cnt`=0.
  - SHIFT: each `bit_en` shifts `sdi` into the shift register LSB and increments `bit_cnt`.
    - When `bit_cnt` reaches DATA_WIDTH, the word is complete. → DONE.
    - A slot start with `bit_cnt` < DATA_WIDTH sets `frame_err`, discards the partial word, and restarts SHIFT for the new channel. If the new channel is right, go to ALIGN instead.
  - DONE: ignores the remaining slot bits until the next slot start, then → SHIFT with channel = new `lrck`.
- Word completion:
  - Output register empty, or `tvalid && tready` in the same cycle: load `tdata` = shift register, `tlast` = channel, `tvalid`=1.
  - Otherwise: drop the word, set `overflow`, force the state to ALIGN. Any emitted right sample is therefore always preceded by its left partner.
- Output register: `tdata` and `tlast` are stable while `tvalid`=1 and `tready`=0. `tvalid` falls after a handshake unless a new word loads in the same cycle.
- Width rules: the shift register is DATA_WIDTH bits and `bit_cnt` is $clog2(DATA_WIDTH+1) bits. A slot must carry at least DATA_WIDTH+1 `sclk` periods, counting the delay bit. Extra LSBs are discarded.
- `overflow` and `frame_err` clear only on `rst`.

## Timing
- Reset values: `tvalid`=0, `tdata`=0, `tlast`=0, `overflow`=0, `frame_err`=0, state=ALIGN.
- Synchronizer flops reset to 0, `lrck_q`=0, `bit_cnt`=0.
- Reset mid-slot discards all partial data. The first beat after reset is always left.
- Latency: `bit_en` occurs SYNC_STAGES+1 `clk` cycles after the `sclk` pin edge.
- `tvalid` rises in the cycle after the `bit_en` that captures the LSB. Total is SYNC_STAGES+2 cycles from the pin edge, i.e. 4 cycles at the default.
- Clock ratio: `sclk` high and low phases must each be at least SYNC_STAGES+1 `clk` periods.
- `lrck` and `sdi` must be stable for one `sclk` period around the rising edge, as I2S guarantees.
- Throughput: one beat per channel slot. A downstream stall shorter than one slot loses nothing.

## Structure
- Shared `i2s_pkg` holds:
  - `i2s_ch_e` (CH_LEFT=0, CH_RIGHT=1), shared with `i2s_tx`.
  - `i2s_rx_state_e` (ALIGN, SHIFT, DONE).
  - `I2S_DEFAULT_DATA_WIDTH` = 24.
- Sub-module `i2s_sync`: parameterized SYNC_STAGES synchronizer with registered rise-detect output, used three times (`sclk` with edge pulse, `lrck`, `sdi`).

## Test plan
- Default params, 64 `sclk` per frame, `clk` = 8× `sclk`, `tready`=1. Left 0xA5A5A5, right 0x5A5A5A → beats 0xA5A5A5/`tlast`=0 then 0x5A5A5A/`tlast`=1. `tvalid` rises 4 `clk` after each LSB `sclk` edge.
- Deassert `rst` while `lrck`=1 mid right slot → no beat until the next left slot. First beat has `tlast`=0.
- Hold `tready`=0 for a full frame (L=0x000001, R=0x000002) → left beat held stable, right dropped, `overflow`=1. After release, the next beat is the following left sample.
- `lrck` toggles after 16 data bits of a left slot → `frame_err`=1, no beat for that slot. The next full-length left slot produces a correct beat.
- Extreme values L=0x800000, R=0x7FFFFF with `tready` toggling every cycle → exact values, no beat duplicated or skipped, `tdata` constant while stalled.
- Assert `rst` one cycle after a beat is presented with `tready`=0 → `tvalid`, `overflow` and `frame_err` all 0 next cycle.
